// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: buffers dispatched ops, wakes operands from the ALU and LSB
// broadcasts, issues the oldest-index ready op each cycle and registers the ALU result onto the CDB.
module alu_rs_scheduler #(
    parameter int RS_SIZE   = 16,
    parameter int RS_IDX_W  = 4,
    parameter int ROB_TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 clr,
    input  logic                 dis_valid,
    input  logic [5:0]           dis_opnum,
    input  logic [ROB_TAG_W-1:0] dis_Q1,
    input  logic [ROB_TAG_W-1:0] dis_Q2,
    input  logic                 dis_Q1_busy,
    input  logic                 dis_Q2_busy,
    input  logic [31:0]          dis_V1,
    input  logic [31:0]          dis_V2,
    input  logic [31:0]          dis_imm,
    input  logic [31:0]          dis_pc,
    input  logic [ROB_TAG_W-1:0] dis_dest,
    output logic                 rs_full,
    input  logic                 lsb_cdb_valid,
    input  logic [ROB_TAG_W-1:0] lsb_cdb_tag,
    input  logic [31:0]          lsb_cdb_data,
    output logic [5:0]           ex_opnum,
    output logic [31:0]          ex_V1,
    output logic [31:0]          ex_V2,
    output logic [31:0]          ex_imm,
    output logic [31:0]          ex_pc,
    input  logic [31:0]          ex_data,
    input  logic [31:0]          ex_target_pc,
    input  logic                 ex_jump,
    input  logic                 ex_valid,
    output logic                 cdb_valid,
    output logic [ROB_TAG_W-1:0] cdb_tag,
    output logic [31:0]          cdb_data,
    output logic [31:0]          cdb_target_pc,
    output logic                 cdb_jump
);

    localparam logic [RS_IDX_W:0] FULL_LVL = (RS_IDX_W + 1)'(RS_SIZE - 1);

    logic [RS_SIZE-1:0]   busy_r;
    logic [RS_SIZE-1:0]   q1_busy_r;
    logic [RS_SIZE-1:0]   q2_busy_r;
    logic [5:0]           op_r   [RS_SIZE];
    logic [ROB_TAG_W-1:0] q1_r   [RS_SIZE];
    logic [ROB_TAG_W-1:0] q2_r   [RS_SIZE];
    logic [ROB_TAG_W-1:0] dest_r [RS_SIZE];
    logic [31:0]          v1_r   [RS_SIZE];
    logic [31:0]          v2_r   [RS_SIZE];
    logic [31:0]          imm_r  [RS_SIZE];
    logic [31:0]          pc_r   [RS_SIZE];

    logic                 issue_valid_r;
    logic [ROB_TAG_W-1:0] issue_tag_r;

    logic                 alu_bc_s;
    logic                 sel_found_s;
    logic [RS_IDX_W-1:0]  sel_idx_s;
    logic                 free_found_s;
    logic [RS_IDX_W-1:0]  free_idx_s;
    logic                 dis_accept_s;
    logic [RS_SIZE-1:0]   busy_next_s;
    logic [RS_IDX_W:0]    busy_cnt_s;
    logic                 dis_q1_busy_s;
    logic                 dis_q2_busy_s;
    logic [31:0]          dis_v1_s;
    logic [31:0]          dis_v2_s;

    function automatic logic tag_hit(input logic                 pending,
                                     input logic [ROB_TAG_W-1:0] q,
                                     input logic                 bc_valid,
                                     input logic [ROB_TAG_W-1:0] bc_tag);
        return pending && bc_valid && (q == bc_tag);
    endfunction

    // The ALU result is visible as a wake-up source in the same cycle it is registered onto the CDB,
    // which gives the two-cycle back-to-back dependence spacing.
    assign alu_bc_s     = issue_valid_r & ex_valid;
    assign dis_accept_s = dis_valid & free_found_s;

    // Lowest-index ready entry for issue and lowest-index free entry for dispatch.
    always_comb begin
        sel_found_s  = 1'b0;
        sel_idx_s    = '0;
        free_found_s = 1'b0;
        free_idx_s   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (busy_r[i] && !q1_busy_r[i] && !q2_busy_r[i]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = RS_IDX_W'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
            if (!busy_r[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = RS_IDX_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Occupancy after this edge, used for the registered full flag.
    always_comb begin
        busy_cnt_s = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_next_s[i] = (busy_r[i] & ~(sel_found_s && (sel_idx_s == RS_IDX_W'(i))))
                           | (dis_accept_s && (free_idx_s == RS_IDX_W'(i)));
            busy_cnt_s = busy_cnt_s + {{RS_IDX_W{1'b0}}, busy_next_s[i]};
        end
    end

    // Same-cycle broadcast bypass into the incoming dispatch.
    always_comb begin
        dis_q1_busy_s = dis_Q1_busy;
        dis_v1_s      = dis_V1;
        dis_q2_busy_s = dis_Q2_busy;
        dis_v2_s      = dis_V2;
        if (tag_hit(dis_Q1_busy, dis_Q1, alu_bc_s, issue_tag_r)) begin
            dis_q1_busy_s = 1'b0;
            dis_v1_s      = ex_data;
        end else if (tag_hit(dis_Q1_busy, dis_Q1, lsb_cdb_valid, lsb_cdb_tag)) begin
            dis_q1_busy_s = 1'b0;
            dis_v1_s      = lsb_cdb_data;
        end else begin
            dis_q1_busy_s = dis_Q1_busy;
            dis_v1_s      = dis_V1;
        end
        if (tag_hit(dis_Q2_busy, dis_Q2, alu_bc_s, issue_tag_r)) begin
            dis_q2_busy_s = 1'b0;
            dis_v2_s      = ex_data;
        end else if (tag_hit(dis_Q2_busy, dis_Q2, lsb_cdb_valid, lsb_cdb_tag)) begin
            dis_q2_busy_s = 1'b0;
            dis_v2_s      = lsb_cdb_data;
        end else begin
            dis_q2_busy_s = dis_Q2_busy;
            dis_v2_s      = dis_V2;
        end
    end

    // Station entries: dispatch write, operand wake-up and release on issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r    <= '0;
            q1_busy_r <= '0;
            q2_busy_r <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_r[i]   <= 6'd0;
                q1_r[i]   <= '0;
                q2_r[i]   <= '0;
                dest_r[i] <= '0;
                v1_r[i]   <= 32'd0;
                v2_r[i]   <= 32'd0;
                imm_r[i]  <= 32'd0;
                pc_r[i]   <= 32'd0;
            end
        end else if (rdy) begin
            if (clr) begin
                busy_r <= '0;
            end else begin
                busy_r <= busy_next_s;
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (tag_hit(busy_r[i] & q1_busy_r[i], q1_r[i], alu_bc_s, issue_tag_r)) begin
                        v1_r[i]      <= ex_data;
                        q1_busy_r[i] <= 1'b0;
                    end else if (tag_hit(busy_r[i] & q1_busy_r[i], q1_r[i], lsb_cdb_valid, lsb_cdb_tag)) begin
                        v1_r[i]      <= lsb_cdb_data;
                        q1_busy_r[i] <= 1'b0;
                    end
                    if (tag_hit(busy_r[i] & q2_busy_r[i], q2_r[i], alu_bc_s, issue_tag_r)) begin
                        v2_r[i]      <= ex_data;
                        q2_busy_r[i] <= 1'b0;
                    end else if (tag_hit(busy_r[i] & q2_busy_r[i], q2_r[i], lsb_cdb_valid, lsb_cdb_tag)) begin
                        v2_r[i]      <= lsb_cdb_data;
                        q2_busy_r[i] <= 1'b0;
                    end
                end
                if (dis_accept_s) begin
                    op_r[free_idx_s]      <= dis_opnum;
                    q1_r[free_idx_s]      <= dis_Q1;
                    q2_r[free_idx_s]      <= dis_Q2;
                    q1_busy_r[free_idx_s] <= dis_q1_busy_s;
                    q2_busy_r[free_idx_s] <= dis_q2_busy_s;
                    v1_r[free_idx_s]      <= dis_v1_s;
                    v2_r[free_idx_s]      <= dis_v2_s;
                    imm_r[free_idx_s]     <= dis_imm;
                    pc_r[free_idx_s]      <= dis_pc;
                    dest_r[free_idx_s]    <= dis_dest;
                end
            end
        end
    end

    // Issue stage, CDB broadcast register and full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_opnum      <= 6'd0;
            ex_V1         <= 32'd0;
            ex_V2         <= 32'd0;
            ex_imm        <= 32'd0;
            ex_pc         <= 32'd0;
            issue_valid_r <= 1'b0;
            issue_tag_r   <= '0;
            cdb_valid     <= 1'b0;
            cdb_tag       <= '0;
            cdb_data      <= 32'd0;
            cdb_target_pc <= 32'd0;
            cdb_jump      <= 1'b0;
            rs_full       <= 1'b0;
        end else if (rdy) begin
            if (clr) begin
                issue_valid_r <= 1'b0;
                cdb_valid     <= 1'b0;
                rs_full       <= 1'b0;
            end else begin
                if (sel_found_s) begin
                    ex_opnum      <= op_r[sel_idx_s];
                    ex_V1         <= v1_r[sel_idx_s];
                    ex_V2         <= v2_r[sel_idx_s];
                    ex_imm        <= imm_r[sel_idx_s];
                    ex_pc         <= pc_r[sel_idx_s];
                    issue_tag_r   <= dest_r[sel_idx_s];
                    issue_valid_r <= 1'b1;
                end else begin
                    issue_valid_r <= 1'b0;
                end
                if (alu_bc_s) begin
                    cdb_valid     <= 1'b1;
                    cdb_tag       <= issue_tag_r;
                    cdb_data      <= ex_data;
                    cdb_target_pc <= ex_target_pc;
                    cdb_jump      <= ex_jump;
                end else begin
                    cdb_valid     <= 1'b0;
                end
                rs_full <= (busy_cnt_s >= FULL_LVL);
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler with a behavioural ALU closing the issue/result loop.
module tb_alu_rs_scheduler;

    logic        clk = 1'b0;
    logic        rst_n, rdy, clr;
    logic        dis_valid;
    logic [5:0]  dis_opnum;
    logic [3:0]  dis_Q1, dis_Q2, dis_dest;
    logic        dis_Q1_busy, dis_Q2_busy;
    logic [31:0] dis_V1, dis_V2, dis_imm, dis_pc;
    logic        rs_full;
    logic        lsb_cdb_valid;
    logic [3:0]  lsb_cdb_tag;
    logic [31:0] lsb_cdb_data;
    logic [5:0]  ex_opnum;
    logic [31:0] ex_V1, ex_V2, ex_imm, ex_pc;
    logic [31:0] ex_data, ex_target_pc;
    logic        ex_jump, ex_valid;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data, cdb_target_pc;
    logic        cdb_jump;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: op 1 subtracts, op 2 is a branch-if-equal, everything else adds.
    assign ex_valid     = 1'b1;
    assign ex_data      = (ex_opnum == 6'd1) ? (ex_V1 - ex_V2) : (ex_V1 + ex_V2);
    assign ex_target_pc = ex_pc + ex_imm;
    assign ex_jump      = (ex_opnum == 6'd2) && (ex_V1 == ex_V2);

    alu_rs_scheduler #(.RS_SIZE(16), .RS_IDX_W(4), .ROB_TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clr(clr),
        .dis_valid(dis_valid), .dis_opnum(dis_opnum),
        .dis_Q1(dis_Q1), .dis_Q2(dis_Q2),
        .dis_Q1_busy(dis_Q1_busy), .dis_Q2_busy(dis_Q2_busy),
        .dis_V1(dis_V1), .dis_V2(dis_V2), .dis_imm(dis_imm), .dis_pc(dis_pc),
        .dis_dest(dis_dest), .rs_full(rs_full),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_data(lsb_cdb_data),
        .ex_opnum(ex_opnum), .ex_V1(ex_V1), .ex_V2(ex_V2), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_data(ex_data), .ex_target_pc(ex_target_pc), .ex_jump(ex_jump), .ex_valid(ex_valid),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_target_pc(cdb_target_pc), .cdb_jump(cdb_jump)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dis_valid     = 1'b0;
        dis_opnum     = 6'd0;
        dis_Q1        = 4'd0;
        dis_Q2        = 4'd0;
        dis_Q1_busy   = 1'b0;
        dis_Q2_busy   = 1'b0;
        dis_V1        = 32'd0;
        dis_V2        = 32'd0;
        dis_imm       = 32'd0;
        dis_pc        = 32'd0;
        dis_dest      = 4'd0;
        lsb_cdb_valid = 1'b0;
        lsb_cdb_tag   = 4'd0;
        lsb_cdb_data  = 32'd0;
        clr           = 1'b0;
    endtask

    task automatic dis(input logic [5:0] op, input logic [3:0] q1, input logic q1b,
                       input logic [3:0] q2, input logic q2b,
                       input logic [31:0] v1, input logic [31:0] v2, input logic [3:0] dest);
        dis_valid   = 1'b1;
        dis_opnum   = op;
        dis_Q1      = q1;
        dis_Q1_busy = q1b;
        dis_Q2      = q2;
        dis_Q2_busy = q2b;
        dis_V1      = v1;
        dis_V2      = v2;
        dis_dest    = dest;
    endtask

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        idle();

        // 1. reset
        step(); step(); step();
        chk("rst_rs_full", 32'(rs_full), 32'd0);
        chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("rst_ex_opnum", 32'(ex_opnum), 32'd0);
        chk("rst_ex_V1", ex_V1, 32'd0);
        rst_n = 1'b1;
        step(); step();
        chk("idle_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("idle_rs_full", 32'(rs_full), 32'd0);

        // 2. single ready ADD
        dis(6'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'd5, 32'd7, 4'd3);
        dis_imm = 32'h10;
        dis_pc  = 32'h40;
        step();
        idle();
        chk("add_E_cdb", 32'(cdb_valid), 32'd0);
        step();
        chk("add_ex_V1", ex_V1, 32'd5);
        chk("add_ex_V2", ex_V2, 32'd7);
        chk("add_ex_pc", ex_pc, 32'h40);
        chk("add_E1_cdb", 32'(cdb_valid), 32'd0);
        step();
        chk("add_cdb_valid", 32'(cdb_valid), 32'd1);
        chk("add_cdb_tag", 32'(cdb_tag), 32'd3);
        chk("add_cdb_data", cdb_data, 32'd12);
        chk("add_cdb_tpc", cdb_target_pc, 32'h50);
        chk("add_cdb_jump", 32'(cdb_jump), 32'd0);
        step();
        chk("add_cdb_drop", 32'(cdb_valid), 32'd0);

        // 3. dependent chain A(dest1) -> B(Q1=1)
        dis(6'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'd10, 32'd20, 4'd1);
        step();
        dis(6'd1, 4'd1, 1'b1, 4'd0, 1'b0, 32'd0, 32'd4, 4'd2);
        step();
        idle();
        chk("chain_A_ex_V1", ex_V1, 32'd10);
        step();
        chk("chain_A_cdb_tag", 32'(cdb_tag), 32'd1);
        chk("chain_A_cdb_data", cdb_data, 32'd30);
        chk("chain_B_not_yet", 32'(ex_opnum), 32'd0);
        step();
        chk("chain_B_ex_op", 32'(ex_opnum), 32'd1);
        chk("chain_B_ex_V1", ex_V1, 32'd30);
        chk("chain_B_ex_V2", ex_V2, 32'd4);
        step();
        chk("chain_B_cdb_valid", 32'(cdb_valid), 32'd1);
        chk("chain_B_cdb_tag", 32'(cdb_tag), 32'd2);
        chk("chain_B_cdb_data", cdb_data, 32'd26);
        step();

        // 4. LSB broadcast bypassed into the same-cycle dispatch
        dis(6'd0, 4'd0, 1'b0, 4'd6, 1'b1, 32'd1, 32'd0, 4'd5);
        lsb_cdb_valid = 1'b1;
        lsb_cdb_tag   = 4'd6;
        lsb_cdb_data  = 32'h100;
        step();
        idle();
        step();
        chk("byp_ex_V2", ex_V2, 32'h100);
        chk("byp_ex_V1", ex_V1, 32'd1);
        step();
        chk("byp_cdb_tag", 32'(cdb_tag), 32'd5);
        chk("byp_cdb_data", cdb_data, 32'h101);
        step();

        // 5. fill 15 entries waiting on tag 9, then release in index order
        for (int i = 0; i < 15; i++) begin
            dis(6'd0, 4'd9, 1'b1, 4'd0, 1'b0, 32'd0, 32'(i), 4'(i));
            step();
            if (i == 13) chk("fill_rs_full_14", 32'(rs_full), 32'd0);
            if (i == 14) chk("fill_rs_full_15", 32'(rs_full), 32'd1);
        end
        idle();
        lsb_cdb_valid = 1'b1;
        lsb_cdb_tag   = 4'd9;
        lsb_cdb_data  = 32'h900;
        step();
        idle();
        chk("fill_wake_full", 32'(rs_full), 32'd1);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("fill_order_V2", ex_V2, 32'(k - 1));
            chk("fill_order_V1", ex_V1, 32'h900);
            if (k == 1) chk("fill_unfull", 32'(rs_full), 32'd0);
            if (k >= 2) begin
                chk("fill_cdb_tag", 32'(cdb_tag), 32'(k - 2));
                chk("fill_cdb_data", cdb_data, 32'h900 + 32'(k - 2));
            end
        end
        step();
        chk("fill_last_tag", 32'(cdb_tag), 32'd14);
        chk("fill_last_data", cdb_data, 32'h90E);
        step();
        chk("fill_done", 32'(cdb_valid), 32'd0);

        // 6. clr with 4 waiting entries and an issue in flight
        for (int i = 0; i < 4; i++) begin
            dis(6'd1, 4'd12, 1'b1, 4'd0, 1'b0, 32'd0, 32'd0, 4'(i));
            step();
        end
        dis(6'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'd1, 32'd1, 4'd7);
        step();
        idle();
        step();
        chk("clr_inflight_V1", ex_V1, 32'd1);
        clr = 1'b1;
        dis(6'd1, 4'd0, 1'b0, 4'd0, 1'b0, 32'd3, 32'd3, 4'd8);
        step();
        idle();
        chk("clr_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("clr_rs_full", 32'(rs_full), 32'd0);
        lsb_cdb_valid = 1'b1;
        lsb_cdb_tag   = 4'd12;
        lsb_cdb_data  = 32'h12;
        step();
        idle();
        chk("clr_no_issue_op", 32'(ex_opnum), 32'd0);
        chk("clr_cdb_quiet1", 32'(cdb_valid), 32'd0);
        step();
        chk("clr_no_issue_op2", 32'(ex_opnum), 32'd0);
        chk("clr_cdb_quiet2", 32'(cdb_valid), 32'd0);
        step();
        chk("clr_cdb_quiet3", 32'(cdb_valid), 32'd0);
        dis(6'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'h20, 32'h22, 4'd10);
        step();
        idle();
        step();
        chk("post_clr_ex_V1", ex_V1, 32'h20);
        step();
        chk("post_clr_cdb_valid", 32'(cdb_valid), 32'd1);
        chk("post_clr_cdb_tag", 32'(cdb_tag), 32'd10);
        chk("post_clr_cdb_data", cdb_data, 32'h42);
        step();

        // 7. rdy low for 5 cycles mid-chain, with junk on every input
        dis(6'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'd3, 32'd4, 4'd1);
        step();
        dis(6'd0, 4'd1, 1'b1, 4'd0, 1'b0, 32'd0, 32'd2, 4'd2);
        step();
        idle();
        step();
        chk("stall_pre_cdb_data", cdb_data, 32'd7);
        rdy = 1'b0;
        clr = 1'b1;
        dis(6'd1, 4'd0, 1'b0, 4'd0, 1'b0, 32'hAA, 32'hBB, 4'd9);
        lsb_cdb_valid = 1'b1;
        lsb_cdb_tag   = 4'd2;
        lsb_cdb_data  = 32'hDEAD;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_cdb_valid", 32'(cdb_valid), 32'd1);
            chk("stall_cdb_tag", 32'(cdb_tag), 32'd1);
            chk("stall_cdb_data", cdb_data, 32'd7);
            chk("stall_ex_V1", ex_V1, 32'd3);
        end
        idle();
        rdy = 1'b1;
        step();
        chk("resume_ex_V1", ex_V1, 32'd7);
        chk("resume_ex_V2", ex_V2, 32'd2);
        chk("resume_cdb_gap", 32'(cdb_valid), 32'd0);
        step();
        chk("resume_cdb_valid", 32'(cdb_valid), 32'd1);
        chk("resume_cdb_tag", 32'(cdb_tag), 32'd2);
        chk("resume_cdb_data", cdb_data, 32'd9);
        step();

        // 8. asynchronous reset with an issue in flight
        dis(6'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'd2, 32'd2, 4'd4);
        step();
        idle();
        step();
        chk("mrst_pre_V1", ex_V1, 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("mrst_ex_V1", ex_V1, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("mrst_after_cdb", 32'(cdb_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
